// File: rtl/johnson_gray_counter.sv
// johnson_gray_counter: N-stage Johnson ring with up/down stepping, clear, load and illegal-word
// recovery, publishing the ring word, its binary index and that index's Gray code.
module johnson_gray_counter #(
   parameter int N = 4,
   localparam int G = $clog2(2*N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         load,
   input  logic [N-1:0] load_val,
   input  logic         en,
   input  logic         dir,
   output logic [N-1:0] johnson,
   output logic [G-1:0] idx,
   output logic [G-1:0] gray,
   output logic         wrap,
   output logic         err
);
   localparam logic [G-1:0] LAST = G'(2*N-1);

   // Legal words are a run of ones anchored at the LSB or (inverted view) at the MSB.
   function automatic logic legal(input logic [N-1:0] w);
      return ((w & (w + N'(1))) == '0) || ((~w & (~w + N'(1))) == '0);
   endfunction

   function automatic logic [G-1:0] to_idx(input logic [N-1:0] w);
      logic [G:0] c = '0;
      for (int i = 0; i < N; i++) c += (G+1)'(w[i]);
      return (w[0] || w == '0) ? c[G-1:0] : G'((G+1)'(2*N) - c);
   endfunction

   logic [N-1:0] johnson_q, johnson_d, step;
   logic [G-1:0] idx_q, idx_d, gray_q, gray_d;
   logic         wrap_q, wrap_d, err_q, err_d, load_ok;

   always_comb begin
      load_ok   = legal(load_val);
      step      = dir ? {johnson_q[N-2:0], ~johnson_q[N-1]} : {~johnson_q[0], johnson_q[N-1:1]};
      johnson_d = clr ? '0 : load ? (load_ok ? load_val : '0) : en ? step : johnson_q;
      err_d     = !clr && (err_q || (load && !load_ok));
      wrap_d    = !clr && !load && en && (dir ? idx_q == LAST : idx_q == '0);
      idx_d     = to_idx(johnson_d);
      gray_d    = idx_d ^ (idx_d >> 1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         johnson_q <= '0;
         idx_q     <= '0;
         gray_q    <= '0;
         wrap_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         johnson_q <= johnson_d;
         idx_q     <= idx_d;
         gray_q    <= gray_d;
         wrap_q    <= wrap_d;
         err_q     <= err_d;
      end
   end

   assign johnson = johnson_q;
   assign idx     = idx_q;
   assign gray    = gray_q;
   assign wrap    = wrap_q;
   assign err     = err_q;
endmodule

// File: tb/tb_johnson_gray_counter.sv
// tb_johnson_gray_counter: scoreboard bench driving N=4 and N=8 counters against an index-level model.
module tb_johnson_gray_counter;
   typedef struct {
      logic [7:0] j;
      logic [3:0] idx;
      logic [3:0] gray;
      logic       wrap;
      logic       err;
      logic       stp;
   } exp_t;

   logic       clk = 0, rst_n = 0, clr = 0, load = 0, en = 0, dir = 0;
   logic [3:0] lv4 = 0;
   logic [7:0] lv8 = 0;
   logic [3:0] j4;
   logic [2:0] i4, g4;
   logic       w4, e4;
   logic [7:0] j8;
   logic [3:0] i8, g8;
   logic       w8, e8;
   int         total = 0, bad = 0;
   int         k[2] = '{0, 0};
   bit         er[2] = '{0, 0};
   exp_t       q4[$], q8[$];
   exp_t       m4, m8, x;
   logic [7:0] pj4 = 0, pj8 = 0;
   logic [3:0] pg4 = 0, pg8 = 0;

   always #5 clk = ~clk;

   johnson_gray_counter #(.N(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(lv4), .en(en), .dir(dir),
      .johnson(j4), .idx(i4), .gray(g4), .wrap(w4), .err(e4));
   johnson_gray_counter #(.N(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(lv8), .en(en), .dir(dir),
      .johnson(j8), .idx(i8), .gray(g8), .wrap(w8), .err(e8));

   // Index k of an n-stage ring: k ones at the bottom, or 2n-k ones at the top.
   function automatic logic [7:0] word_of(int kk, int n);
      int         m = kk <= n ? kk : 2*n - kk;
      logic [7:0] ones = 8'((1 << m) - 1);
      return kk <= n ? ones : 8'(ones << (n - m));
   endfunction

   function automatic int idx_of(logic [7:0] w, int n);
      for (int kk = 0; kk < 2*n; kk++) if (word_of(kk, n) == w) return kk;
      return -1;
   endfunction

   task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h t=%0t", nm, got, want, $time);
      end
   endtask

   task automatic model(int d, int n, logic [7:0] lv, output exp_t e);
      e.wrap = 0;
      e.stp  = 0;
      if (!rst_n || clr) begin
         k[d]  = 0;
         er[d] = 0;
      end else if (load) begin
         int xi = idx_of(lv, n);
         if (xi < 0) begin
            k[d]  = 0;
            er[d] = 1;
         end else k[d] = xi;
      end else if (en) begin
         e.wrap = dir ? k[d] == 2*n - 1 : k[d] == 0;
         e.stp  = 1;
         k[d]   = (k[d] + (dir ? 1 : 2*n - 1)) % (2*n);
      end
      e.j    = word_of(k[d], n);
      e.idx  = 4'(k[d]);
      e.gray = 4'(k[d] ^ (k[d] >> 1));
      e.err  = er[d];
   endtask

   task automatic step(bit r, bit c, bit l, bit e_, bit d_, logic [7:0] v4, logic [7:0] v8);
      @(negedge clk);
      rst_n = r; clr = c; load = l; en = e_; dir = d_; lv4 = v4[3:0]; lv8 = v8;
      model(0, 4, {4'b0, lv4}, x); q4.push_back(x);
      model(1, 8, lv8, x);         q8.push_back(x);
   endtask

   always begin
      @(posedge clk);
      #2;
      if (q4.size() > 0) begin
         m4 = q4.pop_front();
         chk("n4_out", {j4, 1'b0, i4, 1'b0, g4, w4, e4}, {m4.j[3:0], m4.idx, m4.gray, m4.wrap, m4.err});
         if (m4.stp) begin
            chk("n4_gray_1bit", 32'($countones({1'b0, g4} ^ pg4)), 1);
            chk("n4_ring_1bit", 32'($countones({4'b0, j4} ^ pj4)), 1);
         end
      end
      if (q8.size() > 0) begin
         m8 = q8.pop_front();
         chk("n8_out", {j8, i8, g8, w8, e8}, {m8.j, m8.idx, m8.gray, m8.wrap, m8.err});
         if (m8.stp) begin
            chk("n8_gray_1bit", 32'($countones(g8 ^ pg8)), 1);
            chk("n8_ring_1bit", 32'($countones(j8 ^ pj8)), 1);
         end
      end
      pj4 = {4'b0, j4}; pg4 = {1'b0, g4}; pj8 = j8; pg8 = g8;
   end

   initial begin
      step(0, 0, 0, 1, 1, 0, 0);
      step(0, 0, 0, 1, 1, 0, 0);
      repeat (9) step(1, 0, 0, 1, 1, 0, 0);
      step(1, 1, 0, 0, 0, 0, 0);
      repeat (3) step(1, 0, 0, 1, 0, 0, 0);
      step(1, 0, 1, 0, 0, 8'h07, word_of(3, 8));
      step(1, 0, 1, 0, 0, 8'h05, 8'h05);
      repeat (4) step(1, 0, 0, 1, $urandom_range(0, 1), 0, 0);
      step(1, 1, 0, 0, 0, 0, 0);
      step(1, 0, 1, 0, 0, 8'h0a, 8'h81);
      step(1, 0, 1, 0, 0, 8'h0e, word_of(5, 8));
      step(1, 1, 1, 1, 1, 8'h05, 8'h05);
      repeat (400) begin
         bit c = $urandom_range(0, 15) == 0, l = $urandom_range(0, 7) == 0;
         logic [7:0] v4 = $urandom_range(0, 1) ? word_of($urandom_range(0, 7), 4) : 8'($urandom_range(0, 15));
         logic [7:0] v8 = $urandom_range(0, 1) ? word_of($urandom_range(0, 15), 8) : 8'($urandom);
         step(1, c, l, $urandom_range(0, 3) != 0, 1'($urandom), v4, v8);
      end
      step(1, 0, 1, 0, 0, 8'h0c, word_of(6, 8));
      step(1, 0, 0, 0, 1, 0, 0);
      @(negedge clk);
      #3;
      q4.delete(); q8.delete();
      rst_n = 0;
      k = '{0, 0}; er = '{0, 0};
      #1;
      chk("async_rst", {j4, i4, g4, w4, e4, j8, i8, g8, w8, e8}, 0);
      step(0, 0, 0, 1, 1, 0, 0);
      repeat (3) step(1, 0, 0, 1, 1, 0, 0);
      step(1, 1, 0, 0, 0, 0, 0);
      repeat (17) step(1, 0, 0, 1, 1, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0);
      repeat (3) @(negedge clk);
      chk("queue_drained", 32'(q4.size() + q8.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
